mult_div_ctrl: RTL and testbench

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/mult_div_ctrl_if.sv | 39 +++
 rtl/mult_div_ctrl.sv | 109 ++++++++++
 tb/tb_mult_div_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_ctrl_if.sv
// Request/response bundle between the EXE stage, the multiply/divide unit and the HI/LO controller.
// Latency: none (wires only).
// Backpressure: stall/req_ready are carried here; the controller drives them.
// Ports: request (req_valid/req_op/req_a/req_b/flush), EXE results (req_ready/stall/mf_data),
//        unit launch (md_start/md_op/md_in0/md_in1), unit return (md_done/md_res),
//        architectural state (hi/lo/busy).
interface mult_div_ctrl_if #(
  parameter int W = 32
);
  logic           req_valid;
  logic [2:0]     req_op;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic           flush;
  logic           req_ready;
  logic           stall;
  logic [W-1:0]   mf_data;
  logic           md_start;
  logic [7:0]     md_op;
  logic [W-1:0]   md_in0;
  logic [W-1:0]   md_in1;
  logic           md_done;
  logic [2*W-1:0] md_res;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic           busy;

  // master: the pipeline plus the multiply/divide unit
  modport master (
    output req_valid, req_op, req_a, req_b, flush, md_done, md_res,
    input  req_ready, stall, mf_data, md_start, md_op, md_in0, md_in1, hi, lo, busy
  );

  // slave: the HI/LO controller
  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, md_done, md_res,
    output req_ready, stall, mf_data, md_start, md_op, md_in0, md_in1, hi, lo, busy
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// HI/LO controller: launches mult/div ops, commits unit results, serves MTHI/MTLO/MFHI/MFLO.
// Latency: MF combinational, MT at the accept edge, mult/div commit = unit latency + 1 cycle.
// Backpressure: req_ready low in BUSY/DRAIN; stall = req_valid & ~req_ready freezes EXE.
// Ports: clk, rst (async active-high), bus (mult_div_ctrl_if.slave) carrying the request,
//        unit launch/return and hi/lo/busy signals.
module mult_div_ctrl #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mult_div_ctrl_if.slave bus
);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;
  localparam logic [2:0] OP_MFHI = 3'd6;
  localparam logic [2:0] OP_MFLO = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic       accept;
  logic       launch;
  logic       commit;
  logic [7:0] op_onehot;

  // flush in IDLE blocks acceptance but leaves req_ready high
  assign accept    = bus.req_valid & (state == IDLE) & ~bus.flush;
  // codes 0-3 go to the unit; bit 2 selects the HI/LO move group
  assign launch    = accept & ~bus.req_op[2];
  // a flush coinciding with md_done discards the result
  assign commit    = (state == BUSY) & bus.md_done & ~bus.flush;
  assign op_onehot = 8'd1 << bus.req_op[1:0];

  assign bus.req_ready = (state == IDLE);
  assign bus.stall     = bus.req_valid & ~bus.req_ready;
  assign bus.busy      = (state != IDLE);

  always_comb begin
    bus.mf_data = '0;
    case (bus.req_op)
      OP_MFHI: bus.mf_data = bus.hi;
      OP_MFLO: bus.mf_data = bus.lo;
      default: bus.mf_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (launch) state_nxt = BUSY;
      end
      BUSY: begin
        if (bus.md_done)    state_nxt = IDLE;
        else if (bus.flush) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (bus.md_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.hi       <= '0;
      bus.lo       <= '0;
      bus.md_start <= 1'b0;
      bus.md_op    <= '0;
      bus.md_in0   <= '0;
      bus.md_in1   <= '0;
    end else begin
      bus.md_start <= launch;

      // operands stay frozen until the next launch so the unit can sample them at will
      if (launch) begin
        bus.md_op  <= op_onehot;
        bus.md_in0 <= bus.req_a;
        bus.md_in1 <= bus.req_b;
      end else if ((state != IDLE) && (state_nxt == IDLE)) begin
        bus.md_op <= '0;
      end

      if (accept && (bus.req_op == OP_MTHI)) bus.hi <= bus.req_a;
      if (accept && (bus.req_op == OP_MTLO)) bus.lo <= bus.req_a;

      // no divide-by-zero screening: the unit result is committed as returned
      if (commit) begin
        bus.hi <= bus.md_res[2*W-1:W];
        bus.lo <= bus.md_res[W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl; the bench also plays the multiply/divide unit.
// Latency: n/a.
// Backpressure: n/a.
module tb_mult_div_ctrl;
  localparam int W = 32;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_div_ctrl_if #(.W(W)) bus ();

  mult_div_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   shadow_hi;
  logic [W-1:0]   shadow_lo;

  // reference unit: MULT/MULTU -> {hi,lo} product; DIV/DIVU -> {remainder, quotient};
  // a zero divisor returns {a, all-ones}, which the controller must commit untouched
  function automatic logic [2*W-1:0] unit_model(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    logic signed [W-1:0]   sa, sb, q, r;
    logic signed [2*W-1:0] xa, xb;
    sa = a;
    sb = b;
    xa = sa;
    xb = sb;
    case (op)
      OP_MULT:  return xa * xb;
      OP_MULTU: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
      OP_DIV: begin
        if (b == '0) return {a, {W{1'b1}}};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == '0) return {a, {W{1'b1}}};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(1'b0, OP_MULT, '0, '0);
    bus.flush   = 1'b0;
    bus.md_done = 1'b0;
    bus.md_res  = '0;
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.req_ready, bus.md_start, bus.md_op} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_ctrl got busy/ready/start/op=%b want 0/1/0/00",
               {bus.busy, bus.req_ready, bus.md_start, bus.md_op});
    end
    checks++;
    if ({bus.hi, bus.lo, bus.md_in0, bus.md_in1} !== '0) begin
      errors++;
      $display("FAIL reset_regs got hi=%0h lo=%0h in0=%0h in1=%0h want 0", bus.hi, bus.lo,
               bus.md_in0, bus.md_in1);
    end
    // first edge after release must already accept a request
    rst = 1'b0;
    set_req(1'b1, OP_MTHI, 32'hA5A5_0001, '0);
    tick();
    set_req(1'b0, OP_MULT, '0, '0);
    checks++;
    if (bus.hi !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL reset_first_accept got hi=%0h want a5a50001", bus.hi);
    end
    shadow_hi = 32'hA5A5_0001;
    shadow_lo = '0;
  endtask

  task automatic test_mt_mf();
    set_req(1'b1, OP_MTHI, 32'h1234, '0);
    tick();
    shadow_hi = 32'h1234;
    set_req(1'b1, OP_MFHI, '0, '0);
    #1;
    checks++;
    if (bus.mf_data !== 32'h1234) begin
      errors++;
      $display("FAIL mfhi_after_mthi got %0h want 1234", bus.mf_data);
    end
    tick();
    set_req(1'b1, OP_MTLO, 32'h77, '0);
    tick();
    shadow_lo = 32'h77;
    // MTLO under flush: no write, req_ready stays high
    set_req(1'b1, OP_MTLO, 32'hDEAD, '0);
    bus.flush = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.stall} !== 2'b10) begin
      errors++;
      $display("FAIL flush_idle_ready got ready/stall=%b want 10", {bus.req_ready, bus.stall});
    end
    tick();
    // MULT under flush: no launch
    set_req(1'b1, OP_MULT, 32'd5, 32'd6);
    tick();
    bus.flush = 1'b0;
    set_req(1'b0, OP_MULT, '0, '0);
    checks++;
    if ({bus.lo, bus.md_start, bus.busy} !== {shadow_lo, 2'b00}) begin
      errors++;
      $display("FAIL flush_idle_no_effect got lo=%0h start=%b busy=%b want lo=%0h 0 0", bus.lo,
               bus.md_start, bus.busy, shadow_lo);
    end
    // stray md_done in IDLE
    bus.md_done = 1'b1;
    bus.md_res  = {32'hBAD0_0001, 32'hBAD0_0002};
    tick();
    bus.md_done = 1'b0;
    checks++;
    if ({bus.hi, bus.lo, bus.busy} !== {shadow_hi, shadow_lo, 1'b0}) begin
      errors++;
      $display("FAIL idle_done_ignored got hi=%0h lo=%0h busy=%b want hi=%0h lo=%0h busy=0",
               bus.hi, bus.lo, bus.busy, shadow_hi, shadow_lo);
    end
    checks++;
    if (bus.mf_data !== '0) begin
      errors++;
      $display("FAIL mf_data_other_op got %0h want 0", bus.mf_data);
    end
  endtask

  task automatic test_mult();
    logic [2*W-1:0] exp;
    set_req(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3);
    exp_q.push_back(unit_model(OP_MULT, 32'hFFFF_FFFE, 32'd3));
    tick();
    set_req(1'b0, OP_MULT, '0, '0);
    checks++;
    if ({bus.md_start, bus.md_op, bus.busy, bus.req_ready} !== {1'b1, 8'h01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mult_launch got start/op/busy/ready=%b want 1/00000001/1/0",
               {bus.md_start, bus.md_op, bus.busy, bus.req_ready});
    end
    checks++;
    if ({bus.md_in0, bus.md_in1} !== {32'hFFFF_FFFE, 32'd3}) begin
      errors++;
      $display("FAIL mult_operands got %0h/%0h want fffffffe/3", bus.md_in0, bus.md_in1);
    end
    tick();
    checks++;
    if (bus.md_start !== 1'b0) begin
      errors++;
      $display("FAIL mult_start_pulse got %b want 0", bus.md_start);
    end
    bus.md_done = 1'b1;
    bus.md_res  = unit_model(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    tick();
    bus.md_done = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if ({bus.hi, bus.lo} !== exp || exp !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      errors++;
      $display("FAIL mult_commit got %0h want ffffffff_fffffffa", {bus.hi, bus.lo});
    end
    checks++;
    if ({bus.busy, bus.md_op} !== 9'd0) begin
      errors++;
      $display("FAIL mult_return_idle got busy=%b op=%0h want 0/0", bus.busy, bus.md_op);
    end
    shadow_hi = exp[2*W-1:W];
    shadow_lo = exp[W-1:0];
    set_req(1'b1, OP_MFLO, '0, '0);
    #1;
    checks++;
    if ({bus.mf_data, bus.stall} !== {32'hFFFF_FFFA, 1'b0}) begin
      errors++;
      $display("FAIL mult_mflo got data=%0h stall=%b want fffffffa/0", bus.mf_data, bus.stall);
    end
    tick();
    set_req(1'b0, OP_MULT, '0, '0);
  endtask

  task automatic test_divu_stall();
    logic [2*W-1:0] exp;
    set_req(1'b1, OP_DIVU, 32'd100, 32'd7);
    exp_q.push_back(unit_model(OP_DIVU, 32'd100, 32'd7));
    tick();
    set_req(1'b1, OP_MFHI, '0, '0);
    #1;
    checks++;
    if ({bus.stall, bus.req_ready} !== 2'b10) begin
      errors++;
      $display("FAIL divu_stall_start got stall/ready=%b want 10", {bus.stall, bus.req_ready});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.stall, bus.md_in0, bus.md_in1, bus.md_op} !== {1'b1, 32'd100, 32'd7, 8'h08}) begin
        errors++;
        $display("FAIL divu_hold cycle %0d got stall=%b in0=%0h in1=%0h op=%0h want 1/64/7/08",
                 i, bus.stall, bus.md_in0, bus.md_in1, bus.md_op);
      end
    end
    bus.md_done = 1'b1;
    bus.md_res  = unit_model(OP_DIVU, 32'd100, 32'd7);
    tick();
    bus.md_done = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if ({bus.stall, bus.mf_data, bus.lo} !== {1'b0, 32'd2, 32'd14} || {bus.hi, bus.lo} !== exp)
    begin
      errors++;
      $display("FAIL divu_mfhi got stall=%b mf=%0h lo=%0h want 0/2/e", bus.stall, bus.mf_data,
               bus.lo);
    end
    shadow_hi = exp[2*W-1:W];
    shadow_lo = exp[W-1:0];
    tick();
    set_req(1'b0, OP_MULT, '0, '0);
  endtask

  task automatic test_drain();
    set_req(1'b1, OP_DIV, 32'hFFFF_FFCE, 32'd7);
    tick();
    set_req(1'b0, OP_MULT, '0, '0);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++;
    if ({bus.busy, bus.req_ready, bus.hi, bus.lo} !== {2'b10, shadow_hi, shadow_lo}) begin
      errors++;
      $display("FAIL drain_enter got busy=%b ready=%b hi=%0h lo=%0h want 1/0/%0h/%0h", bus.busy,
               bus.req_ready, bus.hi, bus.lo, shadow_hi, shadow_lo);
    end
    // flush again in DRAIN is ignored; an MT request must stall
    bus.flush = 1'b1;
    set_req(1'b1, OP_MTHI, 32'h5555, '0);
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL drain_mt_stall got %b want 1", bus.stall);
    end
    tick();
    bus.flush = 1'b0;
    set_req(1'b0, OP_MULT, '0, '0);
    repeat (26) tick();
    checks++;
    if ({bus.busy, bus.hi} !== {1'b1, shadow_hi}) begin
      errors++;
      $display("FAIL drain_wait got busy=%b hi=%0h want 1/%0h", bus.busy, bus.hi, shadow_hi);
    end
    bus.md_done = 1'b1;
    bus.md_res  = unit_model(OP_DIV, 32'hFFFF_FFCE, 32'd7);
    tick();
    bus.md_done = 1'b0;
    checks++;
    if ({bus.busy, bus.md_op, bus.hi, bus.lo} !== {1'b0, 8'h00, shadow_hi, shadow_lo}) begin
      errors++;
      $display("FAIL drain_exit got busy=%b op=%0h hi=%0h lo=%0h want 0/0/%0h/%0h", bus.busy,
               bus.md_op, bus.hi, bus.lo, shadow_hi, shadow_lo);
    end
  endtask

  task automatic test_flush_done();
    set_req(1'b1, OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    tick();
    set_req(1'b0, OP_MULT, '0, '0);
    bus.flush   = 1'b1;
    bus.md_done = 1'b1;
    bus.md_res  = unit_model(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    tick();
    bus.flush   = 1'b0;
    bus.md_done = 1'b0;
    checks++;
    if ({bus.busy, bus.req_ready, bus.hi, bus.lo} !== {2'b01, shadow_hi, shadow_lo}) begin
      errors++;
      $display("FAIL flush_done got busy=%b ready=%b hi=%0h lo=%0h want 0/1/%0h/%0h", bus.busy,
               bus.req_ready, bus.hi, bus.lo, shadow_hi, shadow_lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]     op;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] exp;
    int             lat;
    for (int i = 0; i < 8; i++) begin
      op  = (i == 0) ? OP_DIVU : 3'($urandom_range(0, 3));
      a   = $urandom;
      b   = (i == 0) ? '0 : $urandom;
      lat = $urandom_range(1, 4);
      set_req(1'b1, op, a, b);
      exp_q.push_back(unit_model(op, a, b));
      tick();
      set_req(1'b0, OP_MULT, '0, '0);
      checks++;
      if ({bus.md_start, bus.md_op, bus.md_in0, bus.md_in1} !== {1'b1, 8'd1 << op[1:0], a, b})
      begin
        errors++;
        $display("FAIL b2b_launch %0d got start=%b op=%0h in0=%0h in1=%0h want 1/%0h/%0h/%0h", i,
                 bus.md_start, bus.md_op, bus.md_in0, bus.md_in1, 8'd1 << op[1:0], a, b);
      end
      tick();
      repeat (lat - 1) tick();
      bus.md_done = 1'b1;
      bus.md_res  = unit_model(op, a, b);
      tick();
      bus.md_done = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_queue %0d got empty want entry", i);
        exp = '0;
      end else begin
        exp = exp_q.pop_front();
        if ({bus.hi, bus.lo, bus.busy} !== {exp, 1'b0}) begin
          errors++;
          $display("FAIL b2b_commit %0d got %0h busy=%b want %0h busy=0", i, {bus.hi, bus.lo},
                   bus.busy, exp);
        end
      end
      shadow_hi = exp[2*W-1:W];
      shadow_lo = exp[W-1:0];
      set_req(1'b1, (i % 2 == 1) ? OP_MFLO : OP_MFHI, '0, '0);
      #1;
      checks++;
      if (bus.mf_data !== ((i % 2 == 1) ? shadow_lo : shadow_hi)) begin
        errors++;
        $display("FAIL b2b_mf %0d got %0h want %0h", i, bus.mf_data,
                 (i % 2 == 1) ? shadow_lo : shadow_hi);
      end
      tick();
    end
    set_req(1'b0, OP_MULT, '0, '0);
  endtask

  task automatic test_rst_mid();
    set_req(1'b1, OP_DIV, 32'd1000, 32'd3);
    tick();
    set_req(1'b0, OP_MULT, '0, '0);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.req_ready, bus.md_start, bus.md_op, bus.hi, bus.lo} !==
        {3'b010, 8'h00, {2*W{1'b0}}}) begin
      errors++;
      $display("FAIL rst_mid_async got busy=%b ready=%b start=%b op=%0h hi=%0h lo=%0h want 0/1/0/0/0/0",
               bus.busy, bus.req_ready, bus.md_start, bus.md_op, bus.hi, bus.lo);
    end
    tick();
    rst = 1'b0;
    bus.md_done = 1'b1;
    bus.md_res  = unit_model(OP_DIV, 32'd1000, 32'd3);
    tick();
    bus.md_done = 1'b0;
    checks++;
    if ({bus.busy, bus.hi, bus.lo} !== {1'b0, {2*W{1'b0}}}) begin
      errors++;
      $display("FAIL rst_mid_stale_done got busy=%b hi=%0h lo=%0h want 0/0/0", bus.busy, bus.hi,
               bus.lo);
    end
  endtask

  initial begin
    test_reset();
    test_mt_mf();
    test_mult();
    test_divu_stall();
    test_drain();
    test_flush_done();
    test_back_to_back();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
